// File: rtl/cc_pkg.sv
// Shared types and widths for the candy-board stimulus transmitter.
package cc_pkg;

   localparam int unsigned BOARD_CELLS = 36;
   localparam int unsigned NUM_STRIPE  = 4;
   localparam int unsigned STP_IDX_W   = 2;
   localparam int unsigned COLOR_W     = 3;
   localparam int unsigned POS_W       = 6;
   localparam int unsigned ACT_W       = 2;
   localparam int unsigned SCORE_W     = 7;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BOARD = 3'd1,
      GAP   = 3'd2,
      ACT   = 3'd3,
      WAIT  = 3'd4,
      DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/cc_board_store.sv
// Board colour array plus stripe descriptors; registered write, combinational read by beat.
module cc_board_store
   import cc_pkg::*;
(
   input  logic                 clk,
   input  logic                 i_cell_we,
   input  logic [POS_W-1:0]     i_cell_addr,
   input  logic [COLOR_W-1:0]   i_cell_color,
   input  logic                 i_stp_we,
   input  logic [STP_IDX_W-1:0] i_stp_idx,
   input  logic [POS_W-1:0]     i_stp_pos,
   input  logic                 i_stp_dir,
   input  logic [POS_W-1:0]     i_rd_idx,
   output logic [COLOR_W-1:0]   o_color_c,
   output logic                 o_stripe_c,
   output logic [POS_W-1:0]     o_pos_c
);

   logic [COLOR_W-1:0] r_cell    [BOARD_CELLS];
   logic [POS_W-1:0]   r_stp_pos [NUM_STRIPE];
   logic               r_stp_dir [NUM_STRIPE];

   // Storage writes; out-of-range cell addresses are dropped, contents are never reset
   always_ff @(posedge clk) begin
      if (i_cell_we && (i_cell_addr < POS_W'(BOARD_CELLS))) begin
         r_cell[i_cell_addr] <= i_cell_color;
      end
      if (i_stp_we) begin
         r_stp_pos[i_stp_idx] <= i_stp_pos;
         r_stp_dir[i_stp_idx] <= i_stp_dir;
      end
   end

   // Beat lookup; stripe fields only exist on the first beats, zero elsewhere
   always_comb begin
      o_color_c  = '0;
      o_stripe_c = 1'b0;
      o_pos_c    = '0;
      if (i_rd_idx < POS_W'(BOARD_CELLS)) begin
         o_color_c = r_cell[i_rd_idx];
      end
      if (i_rd_idx < POS_W'(NUM_STRIPE)) begin
         o_stripe_c = r_stp_dir[i_rd_idx[STP_IDX_W-1:0]];
         o_pos_c    = r_stp_pos[i_rd_idx[STP_IDX_W-1:0]];
      end
   end

endmodule

// File: rtl/cc_stim_tx.sv
// Candy-board protocol transmitter: streams board then actions, then captures the score.
// Optional expected-score check enabled by defining CC_STIM_SCORE_CHECK_EN.
module cc_stim_tx
   import cc_pkg::*;
#(
   parameter int unsigned MAX_ACT     = 8,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_we,
   input  logic [5:0]                   cfg_addr,
   input  logic [2:0]                   cfg_color,
   input  logic                         stp_we,
   input  logic [1:0]                   stp_idx,
   input  logic [5:0]                   stp_pos,
   input  logic                         stp_dir,
   input  logic                         act_we,
   input  logic [$clog2(MAX_ACT)-1:0]   act_idx,
   input  logic [1:0]                   act_code,
   input  logic [$clog2(MAX_ACT):0]     act_len,
   input  logic                         start,
   output logic                         in_valid_1,
   output logic [2:0]                   in_color,
   output logic                         in_stripe,
   output logic [5:0]                   in_starting_pos,
   output logic                         in_valid_2,
   output logic [1:0]                   in_action,
   input  logic                         out_valid,
   input  logic [6:0]                   out_score,
   output logic                         busy,
   output logic                         done,
   output logic [6:0]                   score,
   output logic                         timeout,
`ifdef CC_STIM_SCORE_CHECK_EN
   input  logic [6:0]                   exp_score,
   output logic                         mismatch,
`endif
   output logic                         proto_err
);

   localparam int unsigned AIW = $clog2(MAX_ACT);
   localparam int unsigned ALW = AIW + 1;
   localparam int unsigned WCW = $clog2(TIMEOUT_CYC + 1);

   state_t             r_state;
   logic [POS_W-1:0]   r_beat;
   logic [ALW-1:0]     r_len;
   logic [WCW-1:0]     r_wcnt;
   logic [ACT_W-1:0]   r_act [MAX_ACT];
`ifdef CC_STIM_SCORE_CHECK_EN
   logic [SCORE_W-1:0] r_exp;
`endif

   logic               w_idle;
   logic [POS_W-1:0]   w_rd_idx;
   logic [COLOR_W-1:0] w_color;
   logic               w_stripe;
   logic [POS_W-1:0]   w_pos;
   logic [ALW-1:0]     w_len;
   logic               w_in_stream;

   assign w_idle      = (r_state == IDLE);
   assign w_rd_idx    = w_idle ? '0 : (r_beat + POS_W'(1));
   assign w_len       = (act_len > ALW'(MAX_ACT)) ? ALW'(MAX_ACT) : act_len;
   assign w_in_stream = (r_state == BOARD) || (r_state == GAP) || (r_state == ACT);

   cc_board_store u_store (
      .clk          (clk),
      .i_cell_we    (cfg_we && w_idle),
      .i_cell_addr  (cfg_addr),
      .i_cell_color (cfg_color),
      .i_stp_we     (stp_we && w_idle),
      .i_stp_idx    (stp_idx),
      .i_stp_pos    (stp_pos),
      .i_stp_dir    (stp_dir),
      .i_rd_idx     (w_rd_idx),
      .o_color_c    (w_color),
      .o_stripe_c   (w_stripe),
      .o_pos_c      (w_pos)
   );

   // Action list storage, writable only while idle, never reset
   always_ff @(posedge clk) begin
      if (act_we && w_idle) begin
         r_act[act_idx] <= act_code;
      end
   end

   // Transmit FSM with registered protocol and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         r_beat          <= '0;
         r_len           <= '0;
         r_wcnt          <= '0;
         in_valid_1      <= 1'b0;
         in_color        <= '0;
         in_stripe       <= 1'b0;
         in_starting_pos <= '0;
         in_valid_2      <= 1'b0;
         in_action       <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         score           <= '0;
         timeout         <= 1'b0;
         proto_err       <= 1'b0;
`ifdef CC_STIM_SCORE_CHECK_EN
         r_exp           <= '0;
         mismatch        <= 1'b0;
`endif
      end else begin
         if (out_valid && w_in_stream) begin
            proto_err <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state         <= BOARD;
                  r_beat          <= '0;
                  r_len           <= w_len;
                  busy            <= 1'b1;
                  score           <= '0;
                  timeout         <= 1'b0;
                  proto_err       <= 1'b0;
                  in_valid_1      <= 1'b1;
                  in_color        <= w_color;
                  in_stripe       <= w_stripe;
                  in_starting_pos <= w_pos;
`ifdef CC_STIM_SCORE_CHECK_EN
                  r_exp           <= exp_score;
                  mismatch        <= 1'b0;
`endif
               end
            end
            BOARD: begin
               if (r_beat == POS_W'(BOARD_CELLS - 1)) begin
                  r_state         <= GAP;
                  in_valid_1      <= 1'b0;
                  in_color        <= '0;
                  in_stripe       <= 1'b0;
                  in_starting_pos <= '0;
               end else begin
                  r_beat          <= r_beat + POS_W'(1);
                  in_color        <= w_color;
                  in_stripe       <= w_stripe;
                  in_starting_pos <= w_pos;
               end
            end
            GAP: begin
               r_beat <= '0;
               r_wcnt <= '0;
               if (r_len != '0) begin
                  r_state    <= ACT;
                  in_valid_2 <= 1'b1;
                  in_action  <= r_act[0];
               end else begin
                  r_state    <= WAIT;
               end
            end
            ACT: begin
               if (r_beat == (POS_W'(r_len) - POS_W'(1))) begin
                  r_state    <= WAIT;
                  in_valid_2 <= 1'b0;
                  in_action  <= '0;
               end else begin
                  r_beat    <= r_beat + POS_W'(1);
                  in_action <= r_act[AIW'(r_beat + POS_W'(1))];
               end
            end
            WAIT: begin
               if (out_valid) begin
                  r_state  <= DONE;
                  score    <= out_score;
                  busy     <= 1'b0;
                  done     <= 1'b1;
`ifdef CC_STIM_SCORE_CHECK_EN
                  mismatch <= (out_score != r_exp);
`endif
               end else if (r_wcnt == WCW'(TIMEOUT_CYC - 1)) begin
                  r_state  <= DONE;
                  score    <= '0;
                  timeout  <= 1'b1;
                  busy     <= 1'b0;
                  done     <= 1'b1;
`ifdef CC_STIM_SCORE_CHECK_EN
                  mismatch <= 1'b1;
`endif
               end else begin
                  r_wcnt <= r_wcnt + WCW'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
               done    <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/cc_stim_tx.md
Name: cc_stim_tx

Overview:
- Transmitter end of the candy-board input protocol consumed by the CC scoring block.
- Holds a programmable 6x6 colour board, 4 striped-candy descriptors and an action list.
- On `start`, streams them in protocol order: `in_valid_1` phase, then `in_valid_2` phase.
- Then waits for the scorer's `out_valid`/`out_score` and reports the captured score with status flags. Used as the stimulus/driver side in block-level benches and system integration.

Parameters:
- MAX_ACT, 8: depth of action list; maximum actions per run.
- TIMEOUT_CYC, 1023: cycles allowed in WAIT before timeout.

Ports:
- clk  in  1  clock; all outputs change on rising edge (stable for scorer's falling-edge sampling)
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  board cell write strobe
- cfg_addr  in  6  board cell index 0..35 (row-major); 36..63 ignored
- cfg_color  in  3  colour for cell
- stp_we  in  1  stripe descriptor write strobe
- stp_idx  in  2  stripe slot 0..3
- stp_pos  in  6  stripe starting position
- stp_dir  in  1  0 horizontal, 1 vertical
- act_we  in  1  action write strobe
- act_idx  in  $clog2(MAX_ACT)  action slot
- act_code  in  2  action code
- act_len  in  $clog2(MAX_ACT)+1  number of actions to send, sampled at start
- start  in  1  begin transmission (single-cycle pulse)
- in_valid_1  out  1  board phase valid
- in_color  out  3  cell colour
- in_stripe  out  1  stripe direction (board beats 0..3 only)
- in_starting_pos  out  6  stripe position (board beats 0..3 only)
- in_valid_2  out  1  action phase valid
- in_action  out  2  action code
- out_valid  in  1  scorer result valid
- out_score  in  7  scorer result
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse at run end
- score  out  7  captured out_score, held until next start
- timeout  out  1  sticky; WAIT expired without out_valid
- proto_err  out  1  sticky; out_valid seen before WAIT

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Storage arrays are not reset.
- Config writes accepted only in IDLE; writes while busy are dropped. act_len > MAX_ACT is clamped to MAX_ACT.
- FSM states: IDLE, BOARD, GAP, ACT, WAIT, DONE.
- IDLE: start=1 -> BOARD next cycle. Same cycle: busy=1, score/timeout/proto_err cleared, act_len latched. start outside IDLE is ignored.
- BOARD: exactly 36 consecutive beats, in_valid_1=1, in_color=cell[beat].
  - Beats 0..3: in_stripe=stp_dir[beat], in_starting_pos=stp_pos[beat].
  - Beats 4..35: in_stripe=0, in_starting_pos=0.
  - After beat 35 -> GAP.
- GAP: one idle cycle, all valids 0. Next state: ACT if latched act_len>0, else WAIT.
- ACT: act_len consecutive beats, in_valid_2=1, in_action=act[beat]; then -> WAIT.
- Data outputs are 0 whenever their valid is low. in_valid_1 and in_valid_2 are never high together.
- WAIT: wait counter increments each cycle.
  - out_valid=1 -> score<=out_score, -> DONE.
  - Counter reaches TIMEOUT_CYC with no out_valid -> timeout<=1, score<=0, -> DONE.
  - out_valid and final count in the same cycle: out_valid wins, no timeout.
- out_valid=1 in BOARD/GAP/ACT: proto_err<=1, value not captured, transmission continues.
- DONE: done=1 for one cycle, busy=0, -> IDLE. A start on the next cycle is accepted.
- rst mid-run: next cycle is IDLE, all valids 0, flags cleared. No partial stream resumes.

Optional Feature:
- Macro: CC_STIM_SCORE_CHECK_EN.
- Enabled: adds input exp_score[6:0] (latched at start) and output mismatch (1, sticky until next start). mismatch is set on the out_valid capture if out_score != exp_score, and also set on timeout.
- Disabled: neither port exists; behaviour otherwise identical.

Decomposition:
- Package cc_pkg:
  - State enum: IDLE, BOARD, GAP, ACT, WAIT, DONE.
  - Constants: BOARD_CELLS=36, NUM_STRIPE=4, COLOR_W=3, POS_W=6, ACT_W=2, SCORE_W=7.
- One sub-module, cc_board_store: 36x3 colour array plus 4 stripe descriptors, with write port and combinational read by beat index.
- FSM, action list and counters stay in the top module.

Test Plan:
- Board cell k colour = k%6, stripes {pos 0..3, dir 1,0,1,0}, act_len=2, acts {1,3}, scorer returns 42 at WAIT cycle 5 -> 36 in_valid_1 beats in order, colours 0,1,..5,0.., 1 gap cycle, in_valid_2 beats 1,3, score=42, done pulse, timeout=0.
- act_len=0 -> BOARD, GAP, straight to WAIT; in_valid_2 never asserted; start->done latency = 36+1+wait+1.
- No out_valid -> after 1023 WAIT cycles timeout=1, score=0, done pulse; next start clears timeout.
- out_valid=1 with out_score=9 pulsed during board beat 10 -> proto_err=1, stream continues unbroken, score not 9 unless re-asserted in WAIT.
- start pulsed again, plus cfg_we to cell 0, during ACT -> both ignored; next run shows original cell 0 colour; rst at board beat 20 -> valids 0 next cycle, busy=0, state IDLE.
- Macro enabled, exp_score=17, scorer returns 18 -> mismatch=1; rerun with exp_score=18 -> mismatch=0.
